// File: rtl/reg_cmd_sequencer_pkg.sv
// reg_cmd_pkg: FSM state encoding and protocol bytes shared by the command sequencer.
package reg_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_DATA,
        WRITE,
        RD_CAP,
        TX_DATA,
        TX_ACK,
        TX_ERR
    } state_e;

    localparam logic [7:0] ACK_BYTE      = 8'hA5;
    localparam logic [7:0] ERR_BYTE      = 8'hEE;
    localparam int         CMD_WRITE_BIT = 7;

    function automatic logic id_valid(input logic [6:0] id, input int num_regs);
        return int'({1'b0, id}) < num_regs;
    endfunction

endpackage

// File: rtl/reg_cmd_sequencer_if.sv
// reg_cmd_sequencer_if: host byte link plus register-bank bus; master is the sequencer side.
interface reg_cmd_sequencer_if #(
    parameter int DATA_BITS = 32,
    parameter int NUM_REGS  = 16
) ();

    logic [7:0]                    rx_data;
    logic                          rx_valid;
    logic [7:0]                    tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic [NUM_REGS-1:0]           reg_wr_en;
    logic [DATA_BITS-1:0]          reg_wr_data;
    logic [NUM_REGS*DATA_BITS-1:0] reg_rd_data;
    logic                          busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, reg_rd_data,
        output tx_data, tx_valid, reg_wr_en, reg_wr_data, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, reg_rd_data,
        input  tx_data, tx_valid, reg_wr_en, reg_wr_data, busy
    );

endinterface

// File: rtl/reg_cmd_sequencer_byte_serializer.sv
// byte_serializer: loads one DATA_BITS word and emits it MSB byte first over valid/ready.
module byte_serializer #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] word_i,
    input  logic                 ready_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    output logic                 last_o
);

    localparam int NB = DATA_BITS / 8;

    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [3:0]           left_q, left_d;

    always_comb begin
        sh_d   = sh_q;
        left_d = left_q;
        if (load_i) begin
            sh_d   = word_i;
            left_d = 4'(NB);
        end else if (valid_o && ready_i) begin
            sh_d   = sh_q << 8;
            left_d = left_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            left_q <= '0;
        end else begin
            sh_q   <= sh_d;
            left_q <= left_d;
        end
    end

    assign data_o  = sh_q[DATA_BITS-1 -: 8];
    assign valid_o = left_q != 4'd0;
    assign last_o  = left_q == 4'd1;

endmodule

// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer: parses host read/write command bytes, strobes the register bank,
// and returns read data or ACK/ERR bytes to the host.
module reg_cmd_sequencer
    import reg_cmd_pkg::*;
#(
    parameter int DATA_BITS      = 32,
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic                clk,
    input logic                reset,
    reg_cmd_sequencer_if.master bus
);

    localparam int NB = DATA_BITS / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q, state_d;
    logic [6:0]           id_q, id_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [DATA_BITS-1:0] rd_word;
    logic [NUM_REGS-1:0]  wr_en;
    logic                 ser_load, ser_valid, ser_last;
    logic [7:0]           ser_data;

    always_comb begin
        rd_word = '0;
        wr_en   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (id_q == 7'(i)) rd_word = bus.reg_rd_data[i*DATA_BITS +: DATA_BITS];
            wr_en[i] = (state_q == WRITE) && (id_q == 7'(i));
        end
    end

    // idle counter only runs between data bytes; any received byte restarts it
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        tmo_d    = (state_q == RX_DATA && !bus.rx_valid) ? tmo_q + 1'b1 : '0;
        ser_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    id_d    = bus.rx_data[6:0];
                    cnt_d   = '0;
                    state_d = bus.rx_data[CMD_WRITE_BIT] ? RX_DATA :
                              id_valid(bus.rx_data[6:0], NUM_REGS) ? RD_CAP : TX_ERR;
                end
            end
            RX_DATA: begin
                if (bus.rx_valid) begin
                    wdata_d = (wdata_q << 8) | DATA_BITS'(bus.rx_data);
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'(NB - 1)) state_d = id_valid(id_q, NUM_REGS) ? WRITE : TX_ERR;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = TX_ACK;
            RD_CAP: begin
                ser_load = 1'b1;
                state_d  = TX_DATA;
            end
            TX_DATA: state_d = (bus.tx_ready && ser_last) ? IDLE : TX_DATA;
            TX_ACK,
            TX_ERR:  state_d = bus.tx_ready ? IDLE : state_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

    byte_serializer #(.DATA_BITS(DATA_BITS)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ser_load),
        .word_i  (rd_word),
        .ready_i (bus.tx_ready && state_q == TX_DATA),
        .data_o  (ser_data),
        .valid_o (ser_valid),
        .last_o  (ser_last)
    );

    assign bus.reg_wr_en   = wr_en;
    assign bus.reg_wr_data = wdata_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.tx_valid    = state_q == TX_ACK || state_q == TX_ERR || (state_q == TX_DATA && ser_valid);
    assign bus.tx_data     = state_q == TX_ACK  ? ACK_BYTE :
                             state_q == TX_ERR  ? ERR_BYTE :
                             state_q == TX_DATA ? ser_data : 8'h00;

endmodule
